// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encodings and the arbiter FSM state type shared by
// alu and alu_share_arbiter. No ports.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_PASS = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU.
// Ports:
//   srca_i   in  DATA_WIDTH     operand A
//   srcb_i   in  DATA_WIDTH     operand B
//   op_i     in  OPCODE_LENGTH  operation select
//   result_o out DATA_WIDTH     result; unknown opcodes give 0
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    srca_i,
  input  logic [DATA_WIDTH-1:0]    srcb_i,
  input  logic [OPCODE_LENGTH-1:0] op_i,
  output logic [DATA_WIDTH-1:0]    result_o
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  always_comb begin
    result_o = '0;
    case (op_i)
      OPCODE_LENGTH'(OP_AND):  result_o = srca_i & srcb_i;
      OPCODE_LENGTH'(OP_OR):   result_o = srca_i | srcb_i;
      OPCODE_LENGTH'(OP_ADD):  result_o = srca_i + srcb_i;
      OPCODE_LENGTH'(OP_SUB):  result_o = srca_i - srcb_i;
      // Full-width shift amount: anything >= DATA_WIDTH shifts everything out.
      OPCODE_LENGTH'(OP_SLL):  result_o = srca_i << srcb_i;
      OPCODE_LENGTH'(OP_SRL):  result_o = srca_i >> srcb_i;
      OPCODE_LENGTH'(OP_XOR):  result_o = srca_i ^ srcb_i;
      // Arithmetic shift only looks at the low bits of B.
      OPCODE_LENGTH'(OP_SRA):  result_o = $unsigned($signed(srca_i) >>> srcb_i[SH_W-1:0]);
      OPCODE_LENGTH'(OP_EQ):   result_o = DATA_WIDTH'(srca_i == srcb_i);
      OPCODE_LENGTH'(OP_PASS): result_o = srcb_i;
      OPCODE_LENGTH'(OP_LT):   result_o = DATA_WIDTH'($signed(srca_i) < $signed(srcb_i));
      default:                 result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. The search starts one
// past ptr_i and wraps, so the last winner has lowest priority.
// Ports:
//   req_i       in  N      request vector
//   ptr_i       in  IDX_W  index of the previous winner
//   grant_o     out N      one-hot grant (zero if no request)
//   grant_idx_o out IDX_W  index of the granted bit (0 if none)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between NUM_REQ requesters with
// round-robin grant and one operation in flight. Operands are registered
// before the ALU and the result after it.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot)
//   req_srca/srcb/op        packed per-requester operands, slice i = requester i
//   rsp_valid/rsp_ready     per-requester response handshake (valid one-hot)
//   rsp_result              registered ALU result
//   busy                    high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a request; grant and capture operands in one cycle
// EXEC  | ALU evaluates registered operands; result registered on the edge
// RESP  | result presented to owner until owner's rsp_ready
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_result,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [DATA_WIDTH-1:0]    srca_q, srca_d;
  logic [DATA_WIDTH-1:0]    srcb_q, srcb_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;

  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic [DATA_WIDTH-1:0]    alu_result;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .srca_i   (srca_q),
    .srcb_i   (srcb_q),
    .op_i     (op_q),
    .result_o (alu_result)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    srca_d    = srca_q;
    srcb_d    = srcb_q;
    op_d      = op_q;
    result_d  = result_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          srca_d    = req_srca[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          srcb_d    = req_srcb[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          op_d      = req_op[grant_idx*OPCODE_LENGTH +: OPCODE_LENGTH];
          owner_d   = grant_idx;
          rr_ptr_d  = grant_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        // Only the owner's ready completes the response.
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign rsp_result = result_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_srca;
  logic [N*DW-1:0] req_srcb;
  logic [N*OW-1:0] req_op;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_result;
  logic            busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_srca   (req_srca),
    .req_srcb   (req_srcb),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int last_grant;

  logic [DW-1:0] ta [N];
  logic [DW-1:0] tb [N];
  logic [OW-1:0] top [N];

  // Reference ALU written straight from the opcode table.
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
    logic [DW-1:0] r;
    int sh;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = (b >= 32) ? 32'd0 : (a << b);
      4'd5:  r = (b >= 32) ? 32'd0 : (a >> b);
      4'd6:  r = a ^ b;
      4'd7: begin
        sh = int'(b % 32);
        r  = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8:  r = (a == b) ? 32'd1 : 32'd0;
      4'd9:  r = b;
      4'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Next winner: first set bit after the previous winner, wrapping.
  function automatic int next_grant(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic load(input int i);
    req_srca[i*DW +: DW] = ta[i];
    req_srcb[i*DW +: DW] = tb[i];
    req_op[i*OW +: OW]   = top[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    last_grant = N - 1;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_srca  = '0;
    req_srcb  = '0;
    req_op    = '0;
    #12;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); else n_pass++;
    n_checks++; if (rsp_result !== 32'd0) $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    #3;
    rst_n = 1'b1;
    last_grant = N - 1;
    step();
  endtask

  task automatic test_single();
    ta[0] = 32'd5; tb[0] = 32'd7; top[0] = 4'b0010; load(0);
    req_valid = 4'b0001;
    #2;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else n_pass++;
    step();
    req_valid = '0;
    #2;
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0) $display("FAIL single_exec busy=%b rsp_valid=%b exp busy=1 rsp_valid=0000", busy, rsp_valid); else n_pass++;
    step();
    #2;
    n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); else n_pass++;
    n_checks++; if (rsp_result !== 32'd12) $display("FAIL single_result got=%0d exp=12", rsp_result); else n_pass++;
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    #2;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle busy got=%b exp=0", busy); else n_pass++;
    last_grant = 0;
    step();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0]  expv;
    logic [DW-1:0] expr;
    do_reset();
    for (int i = 0; i < N; i++) begin
      ta[i] = $urandom; tb[i] = $urandom; top[i] = 4'b0011; load(i);
    end
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      expv = 4'b0001 << order[t];
      expr = ta[order[t]] - tb[order[t]];
      #2;
      n_checks++; if (req_ready !== expv) $display("FAIL rr_grant[%0d] got=%b exp=%b", t, req_ready, expv); else n_pass++;
      step();
      ta[order[t]] = $urandom; tb[order[t]] = $urandom; load(order[t]);
      step();
      #2;
      n_checks++; if (rsp_valid !== expv || rsp_result !== expr)
        $display("FAIL rr_rsp[%0d] got valid=%b res=%h exp valid=%b res=%h", t, rsp_valid, rsp_result, expv, expr);
      else n_pass++;
      n_checks++; if (req_ready !== 4'b0) $display("FAIL rr_no_accept_resp[%0d] got=%b exp=0000", t, req_ready); else n_pass++;
      step();
    end
    last_grant = 0;
    req_valid = '0;
    rsp_ready = '0;
    step();
  endtask

  task automatic test_backpressure();
    int g;
    logic [N-1:0]  expv;
    logic [DW-1:0] expr;
    for (int i = 0; i < N; i++) begin
      ta[i] = $urandom; tb[i] = $urandom; top[i] = 4'b0110; load(i);
    end
    req_valid = 4'b1111;
    g = next_grant(4'b1111, last_grant);
    expv = 4'b0001 << g;
    expr = ta[g] ^ tb[g];
    #2;
    n_checks++; if (req_ready !== expv) $display("FAIL bp_grant got=%b exp=%b", req_ready, expv); else n_pass++;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      #2;
      n_checks++; if (rsp_valid !== expv || rsp_result !== expr || req_ready !== 4'b0 || busy !== 1'b1)
        $display("FAIL bp_hold[%0d] got valid=%b res=%h ready=%b busy=%b exp valid=%b res=%h ready=0000 busy=1",
                 c, rsp_valid, rsp_result, req_ready, busy, expv, expr);
      else n_pass++;
      step();
    end
    rsp_ready = expv;
    req_valid = '0;
    step();
    rsp_ready = '0;
    last_grant = g;
  endtask

  task automatic test_opcodes();
    logic [DW-1:0] va [6] = '{32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd9, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [DW-1:0] vb [6] = '{32'd4, 32'd40, 32'd1, 32'd9, 32'h0000_00FF, 32'd1};
    logic [OW-1:0] vo [6] = '{4'b0111, 4'b0100, 4'b1100, 4'b1000, 4'b1111, 4'b0010};
    logic [DW-1:0] vr [6] = '{32'hF800_0000, 32'd0, 32'd1, 32'd1, 32'd0, 32'h8000_0000};
    for (int t = 0; t < 6; t++) begin
      ta[1] = va[t]; tb[1] = vb[t]; top[1] = vo[t]; load(1);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      step();
      #2;
      n_checks++; if (rsp_result !== vr[t] || rsp_valid !== 4'b0010)
        $display("FAIL opcode[%0d] op=%b got res=%h valid=%b exp res=%h valid=0010", t, vo[t], rsp_result, rsp_valid, vr[t]);
      else n_pass++;
      rsp_ready = 4'b0010;
      step();
      rsp_ready = '0;
    end
    last_grant = 1;
  endtask

  task automatic test_reset_mid();
    ta[1] = 32'd3; tb[1] = 32'd4; top[1] = 4'b0010; load(1);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_result !== 32'd0 || busy !== 1'b0)
      $display("FAIL rstmid_outputs got ready=%b valid=%b res=%h busy=%b exp all 0", req_ready, rsp_valid, rsp_result, busy);
    else n_pass++;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    last_grant = N - 1;
    step();
    for (int c = 0; c < 2; c++) begin
      #2;
      n_checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) $display("FAIL rstmid_no_rsp[%0d] valid=%b busy=%b exp 0000/0", c, rsp_valid, busy); else n_pass++;
      step();
    end
    ta[0] = 32'd20; tb[0] = 32'd6; top[0] = 4'b0011; load(0);
    ta[2] = 32'd1;  tb[2] = 32'd1; top[2] = 4'b0010; load(2);
    req_valid = 4'b0101;
    #2;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rstmid_restart got=%b exp=0001", req_ready); else n_pass++;
    step();
    req_valid = '0;
    step();
    #2;
    n_checks++; if (rsp_valid !== 4'b0001 || rsp_result !== 32'd14) $display("FAIL rstmid_rsp got valid=%b res=%0d exp 0001/14", rsp_valid, rsp_result); else n_pass++;
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    last_grant = 0;
  endtask

  task automatic test_non_owner();
    ta[2] = 32'hF0; tb[2] = 32'h0F; top[2] = 4'b0001; load(2);
    req_valid = 4'b0100;
    #2;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL nonowner_grant got=%b exp=0100", req_ready); else n_pass++;
    step();
    req_valid = '0;
    step();
    rsp_ready = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++; if (rsp_valid !== 4'b0100 || busy !== 1'b1 || rsp_result !== 32'hFF)
        $display("FAIL nonowner_hold[%0d] got valid=%b busy=%b res=%h exp 0100/1/ff", c, rsp_valid, busy, rsp_result);
      else n_pass++;
      step();
    end
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    #2;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) $display("FAIL nonowner_release busy=%b valid=%b exp 0/0000", busy, rsp_valid); else n_pass++;
    last_grant = 2;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  newb;
    logic [N-1:0]  expv;
    logic [DW-1:0] expr;
    int g;
    int waits;
    for (int it = 0; it < 60; it++) begin
      newb = 4'($urandom_range(0, 15)) & ~pend;
      for (int i = 0; i < N; i++) begin
        if (newb[i]) begin
          ta[i]  = $urandom;
          tb[i]  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
          top[i] = 4'($urandom_range(0, 15));
          load(i);
        end
      end
      pend = pend | newb;
      req_valid = pend;
      if (pend == 4'b0) begin
        #2;
        n_checks++; if (req_ready !== 4'b0 || busy !== 1'b0) $display("FAIL rand_idle[%0d] ready=%b busy=%b exp 0000/0", it, req_ready, busy); else n_pass++;
        step();
        continue;
      end
      g = next_grant(pend, last_grant);
      expv = 4'b0001 << g;
      expr = alu_ref(ta[g], tb[g], top[g]);
      #2;
      n_checks++; if (req_ready !== expv) $display("FAIL rand_grant[%0d] got=%b exp=%b", it, req_ready, expv); else n_pass++;
      step();
      pend[g] = 1'b0;
      req_valid = pend;
      #2;
      n_checks++; if (req_ready !== 4'b0) $display("FAIL rand_exec_ready[%0d] got=%b exp=0000", it, req_ready); else n_pass++;
      step();
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        rsp_ready = 4'($urandom_range(0, 15)) & ~expv;
        #2;
        n_checks++; if (rsp_valid !== expv || rsp_result !== expr)
          $display("FAIL rand_wait[%0d] got valid=%b res=%h exp valid=%b res=%h", it, rsp_valid, rsp_result, expv, expr);
        else n_pass++;
        step();
      end
      rsp_ready = expv | 4'($urandom_range(0, 15));
      #2;
      n_checks++; if (rsp_valid !== expv || rsp_result !== expr || req_ready !== 4'b0)
        $display("FAIL rand_rsp[%0d] op=%b got valid=%b res=%h ready=%b exp valid=%b res=%h ready=0000",
                 it, top[g], rsp_valid, rsp_result, req_ready, expv, expr);
      else n_pass++;
      step();
      rsp_ready = '0;
      last_grant = g;
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_opcodes();
    test_reset_mid();
    test_non_owner();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
